// File: rtl/tank_pkg.sv
// Shared types, default keymaps and screen constants for the tank controllers.
package tank_pkg;

    // Heading encoding: 0 up, 1 right, 2 down, 3 left.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        FIRE_IDLE = 2'd0,
        FIRE_REQ  = 2'd1,
        FIRE_COOL = 2'd2
    } fire_state_t;

    // Player 1: WASD + space.
    localparam logic [7:0] P1_KEY_UP    = 8'h1A;
    localparam logic [7:0] P1_KEY_DOWN  = 8'h16;
    localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT = 8'h07;
    localparam logic [7:0] P1_KEY_FIRE  = 8'h2C;

    // Player 2: arrow keys + enter.
    localparam logic [7:0] P2_KEY_UP    = 8'h52;
    localparam logic [7:0] P2_KEY_DOWN  = 8'h51;
    localparam logic [7:0] P2_KEY_LEFT  = 8'h50;
    localparam logic [7:0] P2_KEY_RIGHT = 8'h4F;
    localparam logic [7:0] P2_KEY_FIRE  = 8'h28;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int TANK_W_DEF   = 32;
    localparam int TANK_H_DEF   = 32;

    // Signed per-axis displacement: 0 when the axis is idle, -step or +step otherwise.
    function automatic logic signed [10:0] axis_delta(input logic       en,
                                                      input logic       neg,
                                                      input logic [3:0] step);
        logic signed [10:0] mag;
        mag        = $signed({7'd0, step});
        axis_delta = '0;
        if (en) begin
            axis_delta = neg ? -mag : mag;
        end
    endfunction

endpackage

// File: rtl/tank_clamp.sv
// One axis of the position update: 11-bit signed add, then clamp into [0, MAX_POS].
module tank_clamp #(
    parameter int MAX_POS = 608
) (
    input  logic [9:0]         i_pos,
    input  logic signed [10:0] i_delta,
    output logic [9:0]         o_pos
);

    localparam logic signed [10:0] MaxPosS = 11'(MAX_POS);

    logic signed [10:0] w_sum;

    assign w_sum = $signed({1'b0, i_pos}) + i_delta;

    // Saturate at both walls; in-range sums pass straight through.
    always_comb begin
        o_pos = w_sum[9:0];
        if (w_sum < 11'sd0) begin
            o_pos = '0;
        end else if (w_sum > MaxPosS) begin
            o_pos = MaxPosS[9:0];
        end
    end

endmodule

// File: rtl/tank_ctrl.sv
// Per-player tank controller: keycode decode, clamped movement, heading and a
// req/ack shot request with cooldown. Advances once per frame_clk edge.
module tank_ctrl
    import tank_pkg::*;
#(
    parameter int          START_X   = 350,
    parameter int          START_Y   = 400,
    parameter int          START_DIR = 0,
    parameter int unsigned STEP      = 1,
    parameter int          TANK_W    = TANK_W_DEF,
    parameter int          TANK_H    = TANK_H_DEF,
    parameter int          SCREEN_W  = SCREEN_W_DEF,
    parameter int          SCREEN_H  = SCREEN_H_DEF,
    parameter bit          HOLD_MODE = 1'b0,
    parameter int unsigned COOLDOWN  = 30,
    parameter logic [7:0]  KEY_UP    = P1_KEY_UP,
    parameter logic [7:0]  KEY_DOWN  = P1_KEY_DOWN,
    parameter logic [7:0]  KEY_LEFT  = P1_KEY_LEFT,
    parameter logic [7:0]  KEY_RIGHT = P1_KEY_RIGHT,
    parameter logic [7:0]  KEY_FIRE  = P1_KEY_FIRE
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       shot_ack,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [1:0] Dir,
    output logic       Moving,
    output logic       shot_req,
    output logic [9:0] ShotX,
    output logic [9:0] ShotY,
    output logic [1:0] ShotDir
);

    localparam int         CNT_W      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [9:0] StartX     = 10'(START_X);
    localparam logic [9:0] StartY     = 10'(START_Y);
    localparam dir_t       StartDir   = dir_t'(2'(START_DIR));
    localparam logic [9:0] HalfW      = 10'(TANK_W / 2);
    localparam logic [9:0] HalfH      = 10'(TANK_H / 2);
    localparam logic [3:0] Step4      = 4'(STEP);
    localparam logic [CNT_W-1:0] CoolInit = CNT_W'(COOLDOWN - 1);

    // Movement state. Motion always points along r_dir, so only an enable is kept.
    logic [9:0] r_x;
    logic [9:0] r_y;
    dir_t       r_dir;
    logic       r_mot;
    logic       r_moving;

    // Fire state.
    fire_state_t      r_fire_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_shot_req;
    logic [9:0]       r_shot_x;
    logic [9:0]       r_shot_y;
    dir_t             r_shot_dir;

    // Combinational next-state nets.
    logic               w_key_is_dir;
    dir_t               w_dir_next;
    logic               w_mot_next;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;
    logic               w_moving_next;

    fire_state_t      w_fire_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_shot_req_next;
    logic [9:0]       w_shot_x_next;
    logic [9:0]       w_shot_y_next;
    dir_t             w_shot_dir_next;

    // Decode the keycode into a heading and the motion enable for this edge.
    always_comb begin
        w_key_is_dir = 1'b1;
        w_dir_next   = r_dir;
        if (keycode == KEY_UP) begin
            w_dir_next = DIR_UP;
        end else if (keycode == KEY_RIGHT) begin
            w_dir_next = DIR_RIGHT;
        end else if (keycode == KEY_DOWN) begin
            w_dir_next = DIR_DOWN;
        end else if (keycode == KEY_LEFT) begin
            w_dir_next = DIR_LEFT;
        end else begin
            w_key_is_dir = 1'b0;
        end

        if (w_key_is_dir) begin
            w_mot_next = 1'b1;
        end else begin
            w_mot_next = HOLD_MODE ? 1'b0 : r_mot;
        end

        w_dx = axis_delta(w_mot_next && (w_dir_next == DIR_RIGHT || w_dir_next == DIR_LEFT),
                          w_dir_next == DIR_LEFT, Step4);
        w_dy = axis_delta(w_mot_next && (w_dir_next == DIR_UP || w_dir_next == DIR_DOWN),
                          w_dir_next == DIR_UP, Step4);
    end

    tank_clamp #(
        .MAX_POS (SCREEN_W - TANK_W)
    ) u_clamp_x (
        .i_pos   (r_x),
        .i_delta (w_dx),
        .o_pos   (w_x_next)
    );

    tank_clamp #(
        .MAX_POS (SCREEN_H - TANK_H)
    ) u_clamp_y (
        .i_pos   (r_y),
        .i_delta (w_dy),
        .o_pos   (w_y_next)
    );

    // Pinned against a wall means no change, hence not moving.
    assign w_moving_next = (w_x_next != r_x) || (w_y_next != r_y);

    // Register position, heading and motion.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_x      <= StartX;
            r_y      <= StartY;
            r_dir    <= StartDir;
            r_mot    <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_dir    <= w_dir_next;
            r_mot    <= w_mot_next;
            r_moving <= w_moving_next;
        end
    end

    // Fire FSM next state; the shot snapshot uses the post-move position and heading.
    always_comb begin
        w_fire_state_next = r_fire_state;
        w_cnt_next        = r_cnt;
        w_shot_req_next   = r_shot_req;
        w_shot_x_next     = r_shot_x;
        w_shot_y_next     = r_shot_y;
        w_shot_dir_next   = r_shot_dir;

        unique case (r_fire_state)
            FIRE_IDLE: begin
                if (keycode == KEY_FIRE) begin
                    w_fire_state_next = FIRE_REQ;
                    w_shot_req_next   = 1'b1;
                    w_shot_x_next     = w_x_next + HalfW;
                    w_shot_y_next     = w_y_next + HalfH;
                    w_shot_dir_next   = w_dir_next;
                end
            end
            FIRE_REQ: begin
                if (shot_ack) begin
                    w_fire_state_next = FIRE_COOL;
                    w_shot_req_next   = 1'b0;
                    w_cnt_next        = CoolInit;
                end
            end
            FIRE_COOL: begin
                if (r_cnt == '0) begin
                    w_fire_state_next = FIRE_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_fire_state_next = FIRE_IDLE;
                w_shot_req_next   = 1'b0;
            end
        endcase
    end

    // Register the fire FSM; reset drops a pending request at once.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_fire_state <= FIRE_IDLE;
            r_cnt        <= '0;
            r_shot_req   <= 1'b0;
            r_shot_x     <= '0;
            r_shot_y     <= '0;
            r_shot_dir   <= DIR_UP;
        end else begin
            r_fire_state <= w_fire_state_next;
            r_cnt        <= w_cnt_next;
            r_shot_req   <= w_shot_req_next;
            r_shot_x     <= w_shot_x_next;
            r_shot_y     <= w_shot_y_next;
            r_shot_dir   <= w_shot_dir_next;
        end
    end

    assign TankX    = r_x;
    assign TankY    = r_y;
    assign Dir      = r_dir;
    assign Moving   = r_moving;
    assign shot_req = r_shot_req;
    assign ShotX    = r_shot_x;
    assign ShotY    = r_shot_y;
    assign ShotDir  = r_shot_dir;

endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
- Parametrised per-player tank controller, clocked once per video frame.
- Decodes one USB keycode through a configurable keymap and updates the tank's top-left position.
- Clamps the tank inside the playfield, tracks its facing direction, and raises a shot request to the projectile block through a req/ack handshake with a cooldown.
- One instance per player; the top level ties instances to different keymaps and start positions.

Parameters:
- START_X, 350, reset X of the tank's top-left corner
- START_Y, 400, reset Y of the tank's top-left corner
- START_DIR, 0, reset heading (0 up, 1 right, 2 down, 3 left)
- STEP, 1, pixels moved per frame while moving (1..15)
- TANK_W, 32, tank sprite width in pixels
- TANK_H, 32, tank sprite height in pixels
- SCREEN_W, 640, playfield width
- SCREEN_H, 480, playfield height
- HOLD_MODE, 0, 0 = motion latches until another direction key arrives; 1 = tank stops when no direction key is present
- COOLDOWN, 30, frames after an acknowledged shot before another shot may be requested (>=1)
- KEY_UP, 8'h1A, keycode for up
- KEY_DOWN, 8'h16, keycode for down
- KEY_LEFT, 8'h04, keycode for left
- KEY_RIGHT, 8'h07, keycode for right
- KEY_FIRE, 8'h2C, keycode for fire

Ports:
- frame_clk  in  1  frame-rate clock, one rising edge per frame
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  current USB keycode (8'h00 = none)
- shot_ack  in  1  projectile block has accepted the pending shot
- TankX  out  10  tank top-left X
- TankY  out  10  tank top-left Y
- Dir  out  2  current heading
- Moving  out  1  tank moved on the last edge
- shot_req  out  1  a shot is pending
- ShotX  out  10  shot spawn X (tank centre), valid while shot_req
- ShotY  out  10  shot spawn Y (tank centre), valid while shot_req
- ShotDir  out  2  shot heading, valid while shot_req

Behaviour:
- Reset (async): TankX=START_X, TankY=START_Y, Dir=START_DIR, motion=none, Moving=0, shot_req=0, ShotX/ShotY/ShotDir=0, fire FSM=IDLE, cooldown counter=0.
- Key decode on each frame_clk edge.
  - A direction key sets Dir and the motion vector (+/-STEP on one axis).
  - Any other key, including 0, leaves motion unchanged in HOLD_MODE=0 and clears motion in HOLD_MODE=1.
  - KEY_FIRE never changes motion or Dir.
- Position uses zero lag: the new position is computed from the motion selected in the same edge.
  - Arithmetic is 11-bit signed: next = pos + delta.
  - X is clamped to [0, SCREEN_W-TANK_W]; Y is clamped to [0, SCREEN_H-TANK_H].
  - Clamping to a wall keeps Dir at the pressed direction and does not clear motion.
- Moving=1 iff the registered position changed on this edge, so it is 0 when pinned against a wall.
- Fire FSM states: IDLE, REQ, COOL.
  - IDLE -> REQ when keycode==KEY_FIRE. On that edge: shot_req<=1, ShotX<=nextX+TANK_W/2, ShotY<=nextY+TANK_H/2, ShotDir<=next Dir.
  - REQ: shot_req stays 1 and the Shot* outputs stay frozen until shot_ack is sampled high. The tank may keep moving.
  - REQ -> COOL when shot_ack is sampled 1. On that edge: shot_req<=0, counter<=COOLDOWN-1.
  - COOL: counter decrements once per edge; fire keys are ignored. COOL -> IDLE on the edge where counter==0.
  - Holding KEY_FIRE throughout produces auto-fire: exactly one request every COOLDOWN+2 frames when ack is given on the first REQ cycle.
- A stray shot_ack in IDLE or COOL is ignored.
- Reset mid-REQ drops shot_req immediately (asynchronously); no ack is expected afterwards.
- Keycodes not in the keymap are "no key".

Decomposition:
- Package tank_pkg holds:
  - dir_t (2-bit enum UP/RIGHT/DOWN/LEFT)
  - fire_state_t (IDLE/REQ/COOL)
  - default keymap constants for player 1 (WASD 04/07/16/1A, fire 2C) and player 2 (arrows 50/4F/51/52, fire 28)
  - default screen constants
- One sub-module, tank_clamp: combinational 11-bit add-and-clamp, instantiated once per axis.

Test Plan:
- Reset with START_X=350, START_Y=400, then keycode=0 for 5 frames -> TankX=350, TankY=400, Dir=0, Moving=0, shot_req=0.
- HOLD_MODE=0: keycode=07 for 1 frame then 00 for 9 frames -> TankX=360 after 10 frames, Moving=1 throughout, Dir=1. With HOLD_MODE=1 -> TankX=351, then Moving=0.
- Start X=2, STEP=3, keycode=04 for 3 frames -> TankX=0, 0, 0; Moving=1, 0, 0; Dir=3. Right-edge case: X=606 with keycode=07 clamps to 608.
- keycode=2C in IDLE at X=100, Y=200, Dir=2 -> shot_req=1, ShotX=116, ShotY=216, ShotDir=2. Move 3 frames -> Shot* unchanged. shot_ack=1 -> shot_req=0.
- COOLDOWN=4, KEY_FIRE held, ack on the first REQ cycle -> shot_req rises every 6 frames. A fire press during COOL produces no request.
- Assert Reset asynchronously while shot_req=1, between clock edges -> shot_req and position return to reset values before the next edge.
